// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: opcodes, pipeline-controller FSM states and the
// register-usage record produced by the instruction decoder helper.
package rv32i_pkg;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] FENCE  = 7'b0001111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        DRAIN    = 2'd2
    } ctrl_state_e;

    typedef struct packed {
        logic       rs1_used;
        logic       rs2_used;
        logic       rd_written;
        logic       is_load;
        logic       is_fence;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
    } inst_use_t;

    function automatic logic [6:0] opcode_of(input logic [31:0] inst);
        return inst[6:0];
    endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Signal bundle between the 5-stage datapath (master) and pipeline_ctrl (slave).
// dmem handshake: a request is live while dmem_req_MEM_i=1 and completes in the
// cycle dmem_ready_i=1; req without ready is a wait cycle, ready without req is ignored.
interface pipeline_ctrl_if #(
    parameter int CNT_W = 32
);
    import rv32i_pkg::*;

    logic [31:0]      inst_ID_i;
    logic [31:0]      inst_EX_i;
    logic             valid_ID_i;
    logic             valid_EX_i;
    logic             valid_MEM_i;
    logic             valid_WB_i;
    logic             redirect_EX_i;
    logic             dmem_req_MEM_i;
    logic             dmem_ready_i;

    logic             pc_en_o;
    logic             en_IF_ID_o;
    logic             en_ID_EX_o;
    logic             en_EX_MEM_o;
    logic             en_MEM_WB_o;
    logic             flush_IF_ID_o;
    logic             flush_ID_EX_o;
    logic             flush_MEM_WB_o;
    logic [1:0]       state_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] flush_cnt_o;
    logic             err_o;

    modport master (
        output inst_ID_i, inst_EX_i, valid_ID_i, valid_EX_i, valid_MEM_i, valid_WB_i,
        output redirect_EX_i, dmem_req_MEM_i, dmem_ready_i,
        input  pc_en_o, en_IF_ID_o, en_ID_EX_o, en_EX_MEM_o, en_MEM_WB_o,
        input  flush_IF_ID_o, flush_ID_EX_o, flush_MEM_WB_o,
        input  state_o, stall_cnt_o, flush_cnt_o, err_o
    );

    modport slave (
        input  inst_ID_i, inst_EX_i, valid_ID_i, valid_EX_i, valid_MEM_i, valid_WB_i,
        input  redirect_EX_i, dmem_req_MEM_i, dmem_ready_i,
        output pc_en_o, en_IF_ID_o, en_ID_EX_o, en_EX_MEM_o, en_MEM_WB_o,
        output flush_IF_ID_o, flush_ID_EX_o, flush_MEM_WB_o,
        output state_o, stall_cnt_o, flush_cnt_o, err_o
    );

endinterface

// File: rtl/pipeline_ctrl_inst_regs_use.sv
// Decodes which architectural registers an instruction reads/writes and whether
// it is a load or FENCE. A write to x0 is reported as no write.
module inst_regs_use
    import rv32i_pkg::*;
(
    input  logic [31:0] i_inst,
    output inst_use_t   o_use
);

    logic [6:0] w_op;

    assign w_op = opcode_of(i_inst);

    always_comb begin
        o_use = '0;
        o_use.rs1 = i_inst[19:15];
        o_use.rs2 = i_inst[24:20];
        o_use.rd  = i_inst[11:7];
        o_use.rs1_used = (w_op == OP) || (w_op == OP_IMM) || (w_op == LOAD) ||
                         (w_op == STORE) || (w_op == BRANCH) || (w_op == JALR);
        o_use.rs2_used = (w_op == OP) || (w_op == STORE) || (w_op == BRANCH);
        o_use.rd_written = ((w_op == OP) || (w_op == OP_IMM) || (w_op == LOAD) ||
                            (w_op == JAL) || (w_op == JALR) || (w_op == LUI) ||
                            (w_op == AUIPC)) && (i_inst[11:7] != 5'd0);
        o_use.is_load  = (w_op == LOAD);
        o_use.is_fence = (w_op == FENCE);
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard/sequencing controller: load-use interlock, EX redirect flush, dmem wait
// stall with watchdog, FENCE drain, plus saturating stall/flush counters.
module pipeline_ctrl
    import rv32i_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1024,
    parameter int CNT_W       = 32
) (
    input logic            clk_i,
    input logic            rst_ni,
    pipeline_ctrl_if.slave bus
);

    localparam int WAIT_W = $clog2(TIMEOUT_CYC) + 1;

    ctrl_state_e       r_state;
    logic              r_ret_drain;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic              r_err;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_flush_cnt;

    ctrl_state_e w_state_nxt;
    ctrl_state_e w_eff_state;
    logic        w_ret_drain_nxt;
    logic        w_mem_stall;
    logic        w_redirect;
    logic        w_redirect_take;
    logic        w_fence_id;
    logic        w_pipe_busy;
    logic        w_load_use;
    logic        w_pc_en;
    logic        w_en_if_id;
    logic        w_en_id_ex;
    logic        w_en_ex_mem;
    logic        w_en_mem_wb;
    logic        w_flush_if_id;
    logic        w_flush_id_ex;
    logic        w_flush_mem_wb;
    inst_use_t   w_id_use;
    inst_use_t   w_ex_use;

    inst_regs_use u_use_id (.i_inst(bus.inst_ID_i), .o_use(w_id_use));
    inst_regs_use u_use_ex (.i_inst(bus.inst_EX_i), .o_use(w_ex_use));

    assign w_mem_stall = bus.dmem_req_MEM_i && !bus.dmem_ready_i;
    assign w_redirect  = bus.valid_EX_i && bus.redirect_EX_i;
    assign w_fence_id  = bus.valid_ID_i && w_id_use.is_fence;
    assign w_pipe_busy = bus.valid_EX_i || bus.valid_MEM_i || bus.valid_WB_i;
    assign w_load_use  = bus.valid_EX_i && w_ex_use.is_load && w_ex_use.rd_written &&
                         bus.valid_ID_i &&
                         ((w_id_use.rs1_used && (w_id_use.rs1 == w_ex_use.rd)) ||
                          (w_id_use.rs2_used && (w_id_use.rs2 == w_ex_use.rd)));

    // The cycle that ends a memory wait behaves as the state it will return to.
    assign w_eff_state = (r_state == MEM_WAIT) ? (r_ret_drain ? DRAIN : RUN) : r_state;

    always_comb begin
        w_state_nxt     = r_state;
        w_ret_drain_nxt = r_ret_drain;
        w_redirect_take = 1'b0;
        w_pc_en         = 1'b1;
        w_en_if_id      = 1'b1;
        w_en_id_ex      = 1'b1;
        w_en_ex_mem     = 1'b1;
        w_en_mem_wb     = 1'b1;
        w_flush_if_id   = 1'b0;
        w_flush_id_ex   = 1'b0;
        w_flush_mem_wb  = 1'b0;
        if (!rst_ni) begin
            w_state_nxt     = RUN;
            w_ret_drain_nxt = 1'b0;
            w_pc_en         = 1'b0;
            w_en_if_id      = 1'b0;
            w_en_id_ex      = 1'b0;
            w_en_ex_mem     = 1'b0;
            w_en_mem_wb     = 1'b0;
            w_flush_if_id   = 1'b1;
            w_flush_id_ex   = 1'b1;
            w_flush_mem_wb  = 1'b1;
        end else if (w_mem_stall) begin
            w_pc_en        = 1'b0;
            w_en_if_id     = 1'b0;
            w_en_id_ex     = 1'b0;
            w_en_ex_mem    = 1'b0;
            w_en_mem_wb    = 1'b0;
            w_flush_mem_wb = 1'b1;
            w_state_nxt    = MEM_WAIT;
            if (r_state == DRAIN) begin
                w_ret_drain_nxt = 1'b1;
            end
        end else begin
            w_state_nxt     = w_eff_state;
            w_ret_drain_nxt = 1'b0;
            if (w_redirect) begin
                w_redirect_take = 1'b1;
                w_flush_if_id   = 1'b1;
                w_flush_id_ex   = 1'b1;
                w_state_nxt     = RUN;
            end else if ((w_eff_state == DRAIN) || ((w_eff_state == RUN) && w_fence_id)) begin
                // Hold the FENCE in ID until every older instruction has retired.
                if (w_pipe_busy) begin
                    w_pc_en       = 1'b0;
                    w_en_if_id    = 1'b0;
                    w_flush_id_ex = 1'b1;
                    w_state_nxt   = DRAIN;
                end else begin
                    w_state_nxt = RUN;
                end
            end else if (w_load_use) begin
                w_pc_en       = 1'b0;
                w_en_if_id    = 1'b0;
                w_flush_id_ex = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state     <= RUN;
            r_ret_drain <= 1'b0;
            r_wait_cnt  <= '0;
            r_err       <= 1'b0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_ret_drain <= w_ret_drain_nxt;
            if (w_mem_stall) begin
                if (r_wait_cnt < WAIT_W'(TIMEOUT_CYC)) begin
                    r_wait_cnt <= r_wait_cnt + 1'b1;
                end
                if (r_wait_cnt >= WAIT_W'(TIMEOUT_CYC - 1)) begin
                    r_err <= 1'b1;
                end
            end else begin
                r_wait_cnt <= '0;
            end
            if (!w_pc_en && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_redirect_take && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    assign bus.pc_en_o        = w_pc_en;
    assign bus.en_IF_ID_o     = w_en_if_id;
    assign bus.en_ID_EX_o     = w_en_id_ex;
    assign bus.en_EX_MEM_o    = w_en_ex_mem;
    assign bus.en_MEM_WB_o    = w_en_mem_wb;
    assign bus.flush_IF_ID_o  = w_flush_if_id;
    assign bus.flush_ID_EX_o  = w_flush_id_ex;
    assign bus.flush_MEM_WB_o = w_flush_mem_wb;
    assign bus.state_o        = r_state;
    assign bus.stall_cnt_o    = r_stall_cnt;
    assign bus.flush_cnt_o    = r_flush_cnt;
    assign bus.err_o          = r_err;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: load-use, x0 load, redirect, mem wait,
// FENCE drain (with and without a mid-drain stall), watchdog and reset.
module tb_pipeline_ctrl;
    import rv32i_pkg::*;

    // Control vector order: {pc, IF_ID, ID_EX, EX_MEM, MEM_WB, fIF_ID, fID_EX, fMEM_WB}
    localparam logic [7:0] C_NORM  = 8'b11111000;
    localparam logic [7:0] C_LU    = 8'b00111010;
    localparam logic [7:0] C_DRN   = 8'b00111010;
    localparam logic [7:0] C_MEMST = 8'b00000001;
    localparam logic [7:0] C_REDIR = 8'b11111110;
    localparam logic [7:0] C_RST   = 8'b00000111;

    localparam logic [31:0] I_LW_X5  = 32'h0000A283;
    localparam logic [31:0] I_ADD_X6 = 32'h00128333;
    localparam logic [31:0] I_LW_X0  = 32'h0000A003;
    localparam logic [31:0] I_ADD_X0 = 32'h00100333;
    localparam logic [31:0] I_FENCE  = 32'h0FF0000F;
    localparam logic [31:0] I_NOP    = 32'h00000013;

    logic clk = 1'b0;
    logic rst_n;
    int   n_total = 0;
    int   n_bad   = 0;
    int   exp_stall = 0;
    int   exp_flush = 0;
    logic [7:0] w_ctl;

    pipeline_ctrl_if #(.CNT_W(32)) bus ();

    pipeline_ctrl #(.TIMEOUT_CYC(8), .CNT_W(32)) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    assign w_ctl = {bus.pc_en_o, bus.en_IF_ID_o, bus.en_ID_EX_o, bus.en_EX_MEM_o,
                    bus.en_MEM_WB_o, bus.flush_IF_ID_o, bus.flush_ID_EX_o, bus.flush_MEM_WB_o};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [31:0] id_i, input logic [31:0] ex_i,
                         input logic [3:0] valids, input logic redir,
                         input logic req, input logic rdy);
        bus.inst_ID_i      = id_i;
        bus.inst_EX_i      = ex_i;
        bus.valid_ID_i     = valids[3];
        bus.valid_EX_i     = valids[2];
        bus.valid_MEM_i    = valids[1];
        bus.valid_WB_i     = valids[0];
        bus.redirect_EX_i  = redir;
        bus.dmem_req_MEM_i = req;
        bus.dmem_ready_i   = rdy;
    endtask

    // Check combinational controls and state mid-cycle, then step past the edge.
    task automatic cyc(input string tag, input logic [7:0] exp_ctl, input logic [1:0] exp_st);
        @(negedge clk);
        check({tag, ":ctl"}, 32'(w_ctl), 32'(exp_ctl));
        check({tag, ":st"}, 32'(bus.state_o), 32'(exp_st));
        if (!exp_ctl[7] && rst_n) exp_stall++;
        @(posedge clk);
        #1;
    endtask

    task automatic check_cnts(input string tag);
        check({tag, ":stall"}, bus.stall_cnt_o, 32'(exp_stall));
        check({tag, ":flush"}, bus.flush_cnt_o, 32'(exp_flush));
    endtask

    initial begin
        rst_n = 1'b0;
        drive(I_NOP, I_NOP, 4'b0000, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        cyc("reset", C_RST, RUN);
        exp_stall = 0;
        check_cnts("reset");
        check("reset:err", 32'(bus.err_o), 32'd0);
        rst_n = 1'b1;
        cyc("idle", C_NORM, RUN);

        // Load-use: lw x5 in EX, add x6,x5,x1 in ID
        drive(I_ADD_X6, I_LW_X5, 4'b1111, 1'b0, 1'b0, 1'b0);
        cyc("lu", C_LU, RUN);
        drive(I_ADD_X6, I_NOP, 4'b1011, 1'b0, 1'b0, 1'b0);
        cyc("lu_after", C_NORM, RUN);
        check_cnts("lu");

        // Load into x0 never interlocks
        drive(I_ADD_X0, I_LW_X0, 4'b1111, 1'b0, 1'b0, 1'b0);
        cyc("x0", C_NORM, RUN);
        check_cnts("x0");

        // Redirect beats load-use
        drive(I_ADD_X6, I_LW_X5, 4'b1111, 1'b1, 1'b0, 1'b0);
        exp_flush++;
        cyc("redir_lu", C_REDIR, RUN);
        check_cnts("redir_lu");

        // Data-memory wait for three cycles
        drive(I_NOP, I_NOP, 4'b0011, 1'b0, 1'b1, 1'b0);
        cyc("mw1", C_MEMST, RUN);
        cyc("mw2", C_MEMST, MEM_WAIT);
        cyc("mw3", C_MEMST, MEM_WAIT);
        drive(I_NOP, I_NOP, 4'b0011, 1'b0, 1'b1, 1'b1);
        cyc("mw_rdy", C_NORM, MEM_WAIT);
        drive(I_NOP, I_NOP, 4'b0000, 1'b0, 1'b0, 1'b0);
        cyc("mw_done", C_NORM, RUN);
        check_cnts("mw");

        // FENCE drain, one older instruction retiring per cycle
        drive(I_FENCE, I_NOP, 4'b1111, 1'b0, 1'b0, 1'b0);
        cyc("fn_in", C_DRN, RUN);
        drive(I_FENCE, I_NOP, 4'b1011, 1'b0, 1'b0, 1'b0);
        cyc("fn_d1", C_DRN, DRAIN);
        drive(I_FENCE, I_NOP, 4'b1001, 1'b0, 1'b0, 1'b0);
        cyc("fn_d2", C_DRN, DRAIN);
        drive(I_FENCE, I_NOP, 4'b1000, 1'b0, 1'b0, 1'b0);
        cyc("fn_go", C_NORM, DRAIN);
        drive(I_NOP, I_FENCE, 4'b0100, 1'b0, 1'b0, 1'b0);
        cyc("fn_run", C_NORM, RUN);
        check_cnts("fn");

        // Memory stall in the middle of a drain returns to DRAIN
        drive(I_FENCE, I_NOP, 4'b1001, 1'b0, 1'b0, 1'b0);
        cyc("fm_in", C_DRN, RUN);
        drive(I_FENCE, I_NOP, 4'b1001, 1'b0, 1'b1, 1'b0);
        cyc("fm_st", C_MEMST, DRAIN);
        drive(I_FENCE, I_NOP, 4'b1001, 1'b0, 1'b1, 1'b1);
        cyc("fm_rdy", C_DRN, MEM_WAIT);
        drive(I_FENCE, I_NOP, 4'b1000, 1'b0, 1'b0, 1'b0);
        cyc("fm_go", C_NORM, DRAIN);
        drive(I_NOP, I_NOP, 4'b0000, 1'b0, 1'b0, 1'b0);
        cyc("fm_run", C_NORM, RUN);
        check_cnts("fm");

        // Redirect while draining flushes the FENCE and returns to RUN
        drive(I_FENCE, I_NOP, 4'b1100, 1'b0, 1'b0, 1'b0);
        cyc("fr_in", C_DRN, RUN);
        drive(I_FENCE, I_NOP, 4'b1100, 1'b1, 1'b0, 1'b0);
        exp_flush++;
        cyc("fr_redir", C_REDIR, DRAIN);
        drive(I_NOP, I_NOP, 4'b0000, 1'b0, 1'b0, 1'b0);
        cyc("fr_run", C_NORM, RUN);
        check_cnts("fr");

        // Watchdog: eight stalled cycles set the sticky error
        drive(I_NOP, I_NOP, 4'b0000, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            cyc("to", C_MEMST, (i == 0) ? RUN : MEM_WAIT);
            check("to:err", 32'(bus.err_o), (i == 7) ? 32'd1 : 32'd0);
        end
        drive(I_NOP, I_NOP, 4'b0000, 1'b0, 1'b1, 1'b1);
        cyc("to_rdy", C_NORM, MEM_WAIT);
        drive(I_NOP, I_NOP, 4'b0000, 1'b0, 1'b0, 1'b0);
        cyc("to_run", C_NORM, RUN);
        check("to:err_sticky", 32'(bus.err_o), 32'd1);
        check_cnts("to");

        // Reset in the middle of a drain
        drive(I_FENCE, I_NOP, 4'b1100, 1'b0, 1'b0, 1'b0);
        cyc("rd_in", C_DRN, RUN);
        rst_n = 1'b0;
        cyc("rd_rst", C_RST, DRAIN);
        exp_stall = 0;
        exp_flush = 0;
        check_cnts("rd");
        check("rd:err", 32'(bus.err_o), 32'd0);
        check("rd:state", 32'(bus.state_o), 32'(RUN));
        rst_n = 1'b1;
        drive(I_NOP, I_NOP, 4'b0000, 1'b0, 1'b0, 1'b0);
        cyc("rd_run", C_NORM, RUN);
        check_cnts("rd_run");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central hazard and sequencing controller for the 5-stage RV32I pipeline; works alongside forwarding_unit and covers what forwarding cannot resolve. Generates PC enable, per-stage pipeline-register enables and flushes for four cases: load-use interlock, EX-resolved redirect (branch taken, JAL/JALR), data-memory wait, and FENCE drain. Holds a small FSM, a memory-wait watchdog and saturating stall/flush performance counters.

Parameters:
TIMEOUT_CYC, 1024, consecutive dmem wait cycles before err_o is set
CNT_W, 32, width of the performance counters

Ports:
clk_i  in  1  clock
rst_ni  in  1  synchronous reset, active low
inst_ID_i  in  32  instruction in ID
inst_EX_i  in  32  instruction in EX
valid_ID_i / valid_EX_i / valid_MEM_i / valid_WB_i  in  1 each  stage holds a real (non-bubble) instruction
redirect_EX_i  in  1  EX resolved a taken branch/jump; PC mux selects the target this cycle
dmem_req_MEM_i  in  1  MEM stage load/store is issuing a request
dmem_ready_i  in  1  data memory completes the request this cycle
pc_en_o  out  1  PC register load enable
en_IF_ID_o / en_ID_EX_o / en_EX_MEM_o / en_MEM_WB_o  out  1 each  pipeline register enables
flush_IF_ID_o / flush_ID_EX_o / flush_MEM_WB_o  out  1 each  load bubble (valid=0) on the next edge; overrides enable
state_o  out  2  FSM state: 0 RUN, 1 MEM_WAIT, 2 DRAIN
stall_cnt_o  out  CNT_W  cycles with pc_en_o=0, saturating
flush_cnt_o  out  CNT_W  redirect flush events, saturating
err_o  out  1  sticky memory-wait timeout

Behaviour:
- Reset (rst_ni=0 at an edge): state RUN, counters 0, err_o 0, wait_cnt 0, ret_drain 0. While rst_ni=0, outputs: all en=0, pc_en_o=0, all flush=1.
- Decode: load = opcode 0000011. rs1 used for opcodes 0110011, 0010011, 0000011, 0100011, 1100011, 1100111. rs2 used for 0110011, 0100011, 1100011. FENCE = opcode 0001111. rd=x0 never causes a hazard.
- Per-cycle priority: (1) mem stall, (2) redirect, (3) FENCE drain, (4) load-use, (5) normal advance (all en=1, no flush).
- Mem stall (dmem_req_MEM_i & !dmem_ready_i): pc_en and en_IF_ID..en_EX_MEM = 0, flush_MEM_WB_o = 1, everything else ignored. RUN->MEM_WAIT; from DRAIN set ret_drain=1 and go to MEM_WAIT. wait_cnt increments each stalled cycle. At wait_cnt==TIMEOUT_CYC-1, err_o sets and stays set; the stall still holds.
- MEM_WAIT exit: the cycle with dmem_ready_i=1 advances normally (or applies lower priorities). Next state is DRAIN if ret_drain else RUN. wait_cnt and ret_drain clear.
- Redirect (valid_EX_i & redirect_EX_i): pc_en=1, flush_IF_ID=1, flush_ID_EX=1, flush_cnt+1. Overrides load-use and drain; in DRAIN it flushes the FENCE and goes to RUN.
- FENCE drain: in RUN with valid_ID_i & FENCE, go to DRAIN. In DRAIN, while any of valid_EX/MEM/WB is 1: pc_en=0, en_IF_ID=0, flush_ID_EX=1. In the first cycle all three are 0: normal advance (FENCE enters EX), next state RUN. Entry cycle already applies the drain outputs.
- Load-use (valid_EX_i, EX load, rd!=0, ID valid and uses that rd as rs1/rs2): pc_en=0, en_IF_ID=0, flush_ID_EX=1 for exactly one cycle. No state change; it resolves naturally when the load leaves EX.
- stall_cnt_o increments in every cycle with pc_en_o=0 after reset; both counters saturate at all-ones.
- Outputs are combinational from the registered state and the current inputs. No internal pipeline latency.

Decomposition:
- Shared package rv32i_pkg: opcode localparams (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, FENCE) and the ctrl_state_e enum {RUN, MEM_WAIT, DRAIN}. The forwarding unit and decoder reuse them.
- One sub-module, inst_regs_use: given an instruction, returns rs1_used, rs2_used, rd_written, is_load, is_fence. Instantiated twice (ID, EX).

Test Plan:
- Load-use: EX=0x0000A283 (lw x5,0(x1)), ID=0x00128333 (add x6,x5,x1), all valid -> one cycle with pc_en=0, en_IF_ID=0, flush_ID_EX=1; next cycle normal advance; stall_cnt=1.
- x0 load: EX=0x0000A003 (lw x0), ID=0x00100333 -> no stall.
- Redirect plus load-use in the same cycle -> flush_IF_ID=flush_ID_EX=1, pc_en=1, flush_cnt=1, no stall counted.
- Mem wait: dmem_req=1, ready=0 for 3 cycles then 1 -> state_o=1 for 3 cycles; en_* = 0 and flush_MEM_WB=1 during wait; advance on the ready cycle; state RUN.
- FENCE: ID=0x0FF0000F with EX/MEM/WB valid, valids retiring one per cycle -> DRAIN for 3 cycles, then advance and RUN. A mem stall injected mid-drain returns to DRAIN.
- Timeout with TIMEOUT_CYC=8, ready held 0 -> err_o=1 after 8 stall cycles and stays 1 after ready. Reset mid-DRAIN -> RUN, counters 0, all flushes asserted during reset.
